// File: rtl/adder_sum_accumulator_if.sv
// Handshake bundle between the 2-bit adder, the frame accumulator and its consumer.
//   in_valid/in_ready/in_sum/in_carry : sample stream into the accumulator
//   abort                             : drop the partial frame
//   out_valid/out_ready/out_acc/out_ovf/out_frame_cnt : frame total stream
// slave  = accumulator side, master = producer/consumer side.
interface adder_sum_accumulator_if #(
  parameter int ACC_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sum;
  logic             in_carry;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;
  logic [7:0]       out_frame_cnt;

  modport slave (
    input  in_valid, in_sum, in_carry, abort, out_ready,
    output in_ready, out_valid, out_acc, out_ovf, out_frame_cnt
  );

  modport master (
    output in_valid, in_sum, in_carry, abort, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf, out_frame_cnt
  );
endinterface

// File: rtl/adder_sum_accumulator.sv
// Frame accumulator behind the 2-bit ripple adder.
// Sums FRAME_LEN accepted {carry,sum} samples (0..6) into an ACC_W-bit total,
// then holds the total (with a sticky overflow flag) on the output handshake
// until it is taken.
//   clk, rst : clock, synchronous active-high reset
//   bus      : adder_sum_accumulator_if.slave (sample in, frame total out)
module adder_sum_accumulator #(
  parameter int ACC_W     = 8,
  parameter int FRAME_LEN = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  adder_sum_accumulator_if.slave  bus
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_e;

  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;

  logic [ACC_W:0]   sample;
  logic [ACC_W:0]   sum_ext;

  // Data inputs are masked unless valid so undriven data never reaches state.
  always_comb begin
    sample = '0;
    if (bus.in_valid) sample = {{(ACC_W-2){1'b0}}, bus.in_carry, bus.in_sum};
    sum_ext = {1'b0, acc_q} + sample;
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ACCUM: begin
        if (bus.abort) begin
          // abort wins over a sample offered in the same cycle
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (bus.in_valid) begin
          acc_d = sum_ext[ACC_W-1:0];
          ovf_d = ovf_q | sum_ext[ACC_W];
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LAST_IDX) state_d = HOLD;
        end
      end
      HOLD: begin
        // abort is ignored here: a completed frame is always delivered
        if (bus.out_ready) begin
          state_d     = ACCUM;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.in_ready      = (state_q == ACCUM);
  assign bus.out_valid     = (state_q == HOLD);
  assign bus.out_acc       = acc_q;
  assign bus.out_ovf       = ovf_q;
  assign bus.out_frame_cnt = frame_cnt_q;

endmodule
